// File: rtl/mu0_tune_pkg.sv
// Shared types and constants for the MU0 buzzer tune player.
package mu0_tune_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WRITE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_REST,
    S_NEXT,
    S_FINISH,
    S_SILENCE
  } tune_state_e;

  localparam logic [15:0] TERMINATOR  = 16'h0000;
  localparam logic [11:0] BUZZER_ADDR = 12'hFFD;

  // Note word field positions
  localparam int unsigned PROG_BIT = 15;
  localparam int unsigned DUR_MSB  = 11;
  localparam int unsigned DUR_LSB  = 8;
  localparam int unsigned OCT_MSB  = 7;
  localparam int unsigned OCT_LSB  = 4;
  localparam int unsigned NOTE_MSB = 3;
  localparam int unsigned NOTE_LSB = 0;

  // Duration / rest-step field of a note word
  function automatic logic [3:0] note_dur(input logic [15:0] word);
    return word[DUR_MSB:DUR_LSB];
  endfunction

endpackage

// File: rtl/mu0_tune_player_if.sv
// Shared memory port between the tune player (master) and arbiter/RAM (slave).
interface mu0_tune_player_if;
  logic        bus_req;
  logic        bus_gnt;
  logic [11:0] mem_address;
  logic [15:0] mem_read_data;
  logic [15:0] mem_write_data;
  logic        mem_WEn;

  modport master (
    output bus_req, mem_address, mem_write_data, mem_WEn,
    input  bus_gnt, mem_read_data
  );

  modport slave (
    input  bus_req, mem_address, mem_write_data, mem_WEn,
    output bus_gnt, mem_read_data
  );
endinterface

// File: rtl/mu0_tune_player_rest_timer.sv
// Loadable 24-bit down-counter timing rests in units of STEP_CYCLES.
module tune_rest_timer #(
  parameter int unsigned STEP_CYCLES = 800_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] steps_i,
  output logic       expired_o
);

  localparam logic [23:0] STEP = 24'(STEP_CYCLES);

  logic [23:0] count_q, count_d;

  // Load steps*STEP_CYCLES, otherwise count down to zero and hold
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = 24'(steps_i) * STEP;
    end else if (count_q != '0) begin
      count_d = count_q - 24'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Last cycle of the rest: the loaded value N yields exactly N cycles
  assign expired_o = (count_q <= 24'd1);

endmodule

// File: rtl/mu0_tune_player.sv
// Autonomous tune sequencer: fetches note words from RAM and plays them on
// the buzzer register. Optional macro TUNE_LOOP_EN enables looping on the
// terminator when loop_en is high.
module mu0_tune_player
  import mu0_tune_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 800_000,
  parameter logic [11:0] END_ADDR    = 12'hEFF,
  parameter logic [11:0] BUZZER_ADDR = mu0_tune_pkg::BUZZER_ADDR
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [11:0]           base_addr,
  input  logic                  loop_en,
  mu0_tune_player_if.master     mem,
  input  logic                  buzzer_busy,
  output logic                  playing,
  output logic                  done,
  output logic                  overrun,
  output logic [11:0]           cur_addr
);

  tune_state_e state_q, state_d;
  logic [11:0] ptr_q, ptr_d;
  logic [15:0] note_q, note_d;
  logic        overrun_q, overrun_d;
  logic [1:0]  wait_q, wait_d;
  logic        rest_load, rest_expired;
  logic        done_d;

  logic        bus_req_q;
  logic [11:0] addr_q;
  logic [15:0] wdata_q;
  logic        playing_q, done_q;

  logic        loop_take;
  logic [11:0] loop_addr;

`ifdef TUNE_LOOP_EN
  logic [11:0] base_q;

  // Remember the tune start address for looping
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      base_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      base_q <= base_addr;
    end
  end

  assign loop_take = loop_en;
  assign loop_addr = base_q;
`else
  logic unused_loop_en;
  assign unused_loop_en = loop_en;
  assign loop_take      = 1'b0;
  assign loop_addr      = '0;
`endif

  tune_rest_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_rest_timer (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .load_i   (rest_load),
    .steps_i  (note_dur(note_q)),
    .expired_o(rest_expired)
  );

  // Next-state logic; stop overrides every other transition
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    note_d    = note_q;
    overrun_d = overrun_q;
    wait_d    = wait_q;
    rest_load = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d     = base_addr;
          overrun_d = 1'b0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        if (mem.bus_gnt) begin
          note_d  = mem.mem_read_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (note_q == TERMINATOR) begin
          if (loop_take) begin
            ptr_d   = loop_addr;
            state_d = S_FETCH;
          end else begin
            state_d = S_FINISH;
          end
        end else if (note_dur(note_q) == 4'd0) begin
          state_d = S_NEXT;
        end else if (note_q[PROG_BIT]) begin
          state_d = S_WRITE;
        end else begin
          rest_load = 1'b1;
          state_d   = S_REST;
        end
      end
      S_WRITE: begin
        if (mem.bus_gnt) begin
          wait_d  = '0;
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (buzzer_busy) begin
          state_d = S_WAIT_LO;
        end else if (wait_q == 2'd3) begin
          state_d = S_NEXT;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_WAIT_LO: begin
        if (!buzzer_busy) state_d = S_NEXT;
      end
      S_REST: begin
        if (rest_expired) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (ptr_q == END_ADDR) begin
          overrun_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          ptr_d   = ptr_q + 12'd1;
          state_d = S_FETCH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      S_SILENCE: begin
        if (mem.bus_gnt) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Stop discards whatever this cycle would have changed
    if (stop && state_q != S_IDLE) begin
      state_d   = S_SILENCE;
      ptr_d     = ptr_q;
      note_d    = note_q;
      overrun_d = overrun_q;
      rest_load = 1'b0;
      done_d    = 1'b0;
    end

    if (state_d == S_FINISH) done_d = 1'b1;
  end

  // State and registered outputs, the latter decoded from next state
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      note_q    <= '0;
      overrun_q <= 1'b0;
      wait_q    <= '0;
      bus_req_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      note_q    <= note_d;
      overrun_q <= overrun_d;
      wait_q    <= wait_d;
      bus_req_q <= (state_d == S_FETCH) || (state_d == S_WRITE) || (state_d == S_SILENCE);
      addr_q    <= (state_d == S_FETCH) ? ptr_d :
                   ((state_d == S_WRITE) || (state_d == S_SILENCE)) ? BUZZER_ADDR : '0;
      wdata_q   <= (state_d == S_WRITE) ? note_d : '0;
      playing_q <= (state_d != S_IDLE);
      done_q    <= done_d;
    end
  end

  assign mem.bus_req        = bus_req_q;
  assign mem.mem_address    = addr_q;
  assign mem.mem_write_data = wdata_q;
  assign mem.mem_WEn        = bus_req_q & mem.bus_gnt &
                              ((state_q == S_WRITE) || (state_q == S_SILENCE));

  assign playing  = playing_q;
  assign done     = done_q;
  assign overrun  = overrun_q;
  assign cur_addr = ptr_q;

endmodule

// File: doc/mu0_tune_player.md
# mu0_tune_player

Autonomous tune sequencer for the MU0 lab board buzzer. Once started, it fetches a list of 16-bit note words from RAM through a shared memory port and writes each one to the buzzer register at 12'hFFD. It waits for the buzzer to finish each note before moving on, and it can insert silent rests. It sits beside the CPU and Ackie as a third bus master, and an external arbiter grants it access to the memory port one cycle at a time.

## Interface
Parameters:
- STEP_CYCLES, 800_000: clock cycles per rest time step (1/10 s at 8 MHz).
- END_ADDR, 12'hEFF: highest RAM address the player may fetch from.
- BUZZER_ADDR, 12'hFFD: address of the buzzer register.

Ports:
- Clk  in  1  system clock, 8 MHz, all state on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a tune at base_addr. Ignored unless idle.
- stop  in  1  single-cycle pulse; aborts the tune and silences the buzzer.
- base_addr  in  12  address of the first note word, sampled on the start cycle.
- loop_en  in  1  restart at base_addr on the terminator (TUNE_LOOP_EN only).
- bus_req  out  1  request for the memory port.
- bus_gnt  in  1  grant from the arbiter; an access completes in any cycle where bus_req and bus_gnt are both high.
- mem_address  out  12  access address.
- mem_read_data  in  16  RAM read data, valid in the same cycle as the address.
- mem_write_data  out  16  write data.
- mem_WEn  out  1  write enable, active high; equals bus_req & bus_gnt & (state is WRITE or SILENCE).
- buzzer_busy  in  1  status of the buzzer program mode.
- playing  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when a tune ends or is aborted.
- overrun  out  1  sticky; set when the tune runs past END_ADDR, cleared by start.
- cur_addr  out  12  address of the current note word.

## Operation
Note word format:
- 16'h0000: terminator.
- [15]=1: program-mode note. [11:8] is the duration, [7:4] the octave, [3:0] the note. A duration of 0 means the word is skipped with no write.
- [15]=0 and nonzero: rest of [11:8] time steps. A rest of 0 steps is skipped.

States:
- IDLE: on start, load ptr←base_addr, clear overrun, go to FETCH.
- FETCH: bus_req=1, mem_address=ptr. On grant, latch the word into note_q and go to DECODE.
- DECODE:
  - Terminator: go to FINISH.
  - Skipped word: go to NEXT.
  - Note: go to WRITE.
  - Rest: load the rest timer and go to REST.
- WRITE: bus_req=1, mem_address=BUZZER_ADDR, mem_write_data=note_q. On grant, go to WAIT_HI.
- WAIT_HI: wait for buzzer_busy=1, then go to WAIT_LO. If busy is not seen within 4 cycles, go to NEXT.
- WAIT_LO: when buzzer_busy=0, go to NEXT.
- REST: count [11:8]×STEP_CYCLES cycles, then go to NEXT.
- NEXT: if ptr==END_ADDR, set overrun and go to FINISH. Otherwise ptr←ptr+1 and go to FETCH.
- FINISH: pulse done and go to IDLE.
- SILENCE: bus_req=1, write 16'h0000 to BUZZER_ADDR. On grant, pulse done and go to IDLE.

Stop handling:
- A stop pulse in any state other than IDLE goes to SILENCE. This includes a stop in FETCH or WRITE while waiting for grant; the pending access is dropped.
- A stop pulse in IDLE is ignored.
- Stop has priority over start and over any same-cycle transition.
- A start pulse while playing is ignored.

Reset values:
- State IDLE, ptr=0, note_q=0, rest counter=0.
- bus_req=0, mem_WEn=0, mem_address=0, mem_write_data=0.
- playing=0, done=0, overrun=0, cur_addr=0.
- Reset mid-tune leaves the buzzer register untouched.

Widths:
- The rest counter is 24 bits (maximum 15×800_000 = 12_000_000).
- ptr does not wrap; END_ADDR bounds it.

## Timing
- Start to first bus_req: 1 cycle (start sampled at edge N, bus_req high after N).
- FETCH with grant held high: word latched at the next edge, so there is 1 cycle per access.
- Zero-wait-grant overhead per note:
  - FETCH, DECODE, WRITE, WAIT_HI, then NEXT: 5 cycles plus the buzzer duration.
  - buzzer_busy rises 2 cycles after the write edge.
- Rest length: exactly [11:8]×STEP_CYCLES cycles in REST.
- Grant withheld: the state holds, and address and data stay stable.

## Configuration
Macro TUNE_LOOP_EN:
- Defined: on the terminator with loop_en=1, ptr←base_addr latched at start and the player returns to FETCH; done is not pulsed. With loop_en=0 it goes to FINISH.
- Undefined: the loop_en port exists but is ignored, and the terminator always goes to FINISH.

## Structure
- Package mu0_tune_pkg holds:
  - the state enum;
  - the constants TERMINATOR=16'h0000 and BUZZER_ADDR;
  - field positions for the program bit, duration, octave and note.
- One sub-module, tune_rest_timer: loadable 24-bit down-counter with load and expired signals, parameterised by STEP_CYCLES.

## Test plan
- Single note, gnt tied 1: RAM[0x100]=16'h8153, RAM[0x101]=0; start with base 0x100.
  - Expect one write of 16'h8153 to 12'hFFD.
  - Expect playing to stay high through the 1-step buzzer busy.
  - Expect done a few cycles after busy falls.
- Rest, with STEP_CYCLES=10 in the bench: RAM=16'h0300, 16'h0000.
  - Expect no buzzer write.
  - Expect exactly 30 cycles in REST, then done.
- Arbitration: bus_gnt low for 7 cycles during FETCH.
  - Expect bus_req and mem_address stable, with no state advance.
  - Expect mem_WEn never high without gnt.
- Stop mid-note: stop during WAIT_LO.
  - Expect a write of 16'h0000 to 12'hFFD, done pulsed, playing=0.
  - Expect a later start to work normally.
- Overrun: base 12'hEFF holds 16'h8101 and has no terminator.
  - Expect one write, then overrun=1 and done.
  - Expect no fetch from 12'hF00.
- Loop (TUNE_LOOP_EN): with loop_en=1, expect the second fetch of base after the terminator, and no done until stop.
